// File: rtl/axi_rd_router_pkg.sv
// Shared types for the AXI read router: routing targets, the default-slave
// error response and the default-slave FSM states.
package axi_rd_router_pkg;

    // Routing target: one of up to eight real slaves, or the internal default slave.
    typedef enum logic [3:0] {
        SLV0 = 4'd0,
        SLV1 = 4'd1,
        SLV2 = 4'd2,
        SLV3 = 4'd3,
        SLV4 = 4'd4,
        SLV5 = 4'd5,
        SLV6 = 4'd6,
        SLV7 = 4'd7,
        DEF  = 4'd8
    } target_e;

    localparam int TGT_W = 4;

    // Response returned for reads that decode to no real slave.
    localparam logic [1:0] DEF_RESP = 2'b11;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_RESP = 1'b1
    } ds_state_e;

endpackage

// File: rtl/axi_rd_router_defslv.sv
// Default read slave: accepts one burst at a time and answers every beat
// with DECERR, zero data and the requesting ID.
module axi_default_rd_slave
    import axi_rd_router_pkg::*;
#(
    parameter int ID_BITS   = 4,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 i_arvalid,
    input  logic [ID_BITS-1:0]   i_arid,
    input  logic [LEN_BITS-1:0]  i_arlen,
    output logic                 o_arready,
    output logic                 o_rvalid,
    output logic [ID_BITS-1:0]   o_rid,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic [1:0]           o_rresp,
    output logic                 o_rlast,
    input  logic                 i_rready
);

    ds_state_e           r_state;
    logic [LEN_BITS-1:0] r_beat;
    logic [ID_BITS-1:0]  r_id;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;

    // Burst FSM; handshake-facing outputs are registered alongside the state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= DS_IDLE;
            r_beat    <= '0;
            r_id      <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
        end else begin
            case (r_state)
                DS_IDLE: begin
                    if (i_arvalid) begin
                        r_id      <= i_arid;
                        r_beat    <= i_arlen;
                        r_rlast   <= (i_arlen == '0);
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= DS_RESP;
                    end
                end
                DS_RESP: begin
                    if (i_rready) begin
                        if (r_beat == '0) begin
                            r_arready <= 1'b1;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_state   <= DS_IDLE;
                        end else begin
                            r_beat  <= r_beat - 1'b1;
                            r_rlast <= (r_beat == LEN_BITS'(1));
                        end
                    end
                end
                default: r_state <= DS_IDLE;
            endcase
        end
    end

    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rid     = r_id;
    assign o_rdata   = '0;
    assign o_rresp   = DEF_RESP;
    assign o_rlast   = r_rlast;

endmodule

// File: rtl/axi_rd_router.sv
// AXI read router: one master to NUM_SLAVES read slaves plus an internal
// DECERR slave. Only one target may have bursts outstanding at a time, so
// R beats return in AR order with no reorder buffering.
module axi_rd_router
    import axi_rd_router_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int MAX_OUT    = 4,
    parameter int ID_BITS    = 4,
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int LEN_BITS   = 4
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    // master AR
    input  logic [ID_BITS-1:0]                    ARID_M,
    input  logic [ADDR_BITS-1:0]                  ARADDR_M,
    input  logic [LEN_BITS-1:0]                   ARLEN_M,
    input  logic                                  ARVALID_M,
    output logic                                  ARREADY_M,
    // slave AR (shared payload)
    output logic [ID_BITS-1:0]                    ARID_S,
    output logic [ADDR_BITS-1:0]                  ARADDR_S,
    output logic [LEN_BITS-1:0]                   ARLEN_S,
    output logic [NUM_SLAVES-1:0]                 ARVALID_S,
    input  logic [NUM_SLAVES-1:0]                 ARREADY_S,
    // slave R
    input  logic [NUM_SLAVES-1:0][ID_BITS-1:0]    RID_S,
    input  logic [NUM_SLAVES-1:0][DATA_BITS-1:0]  RDATA_S,
    input  logic [NUM_SLAVES-1:0][1:0]            RRESP_S,
    input  logic [NUM_SLAVES-1:0]                 RLAST_S,
    input  logic [NUM_SLAVES-1:0]                 RVALID_S,
    output logic [NUM_SLAVES-1:0]                 RREADY_S,
    // master R
    output logic [ID_BITS-1:0]                    RID_M,
    output logic [DATA_BITS-1:0]                  RDATA_M,
    output logic [1:0]                            RRESP_M,
    output logic                                  RLAST_M,
    output logic                                  RVALID_M,
    input  logic                                  RREADY_M
);

    localparam int IDX_W = ADDR_BITS - 16;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [IDX_W-1:0]     w_idx;
    target_e              w_tgt;
    logic                 w_adm;
    logic                 w_sel_arready;
    logic                 w_ar_hs;
    logic                 w_rlast_hs;
    logic                 w_busy;

    logic [CNT_W-1:0]     r_cnt;
    target_e              r_cur_tgt;

    logic                 w_def_arvalid;
    logic                 w_def_arready;
    logic                 w_def_rvalid;
    logic [ID_BITS-1:0]   w_def_rid;
    logic [DATA_BITS-1:0] w_def_rdata;
    logic [1:0]           w_def_rresp;
    logic                 w_def_rlast;
    logic                 w_def_rready;

    assign w_idx  = ARADDR_M[ADDR_BITS-1:16];
    assign w_tgt  = (w_idx < IDX_W'(NUM_SLAVES)) ? target_e'(w_idx[TGT_W-1:0]) : DEF;
    assign w_busy = (r_cnt != '0);

    // A new AR may only join bursts already in flight to the same real slave;
    // switching targets waits for the pipe to drain so R order stays AR order.
    assign w_adm = !w_busy ||
                   ((r_cnt < CNT_W'(MAX_OUT)) && (w_tgt == r_cur_tgt) && (r_cur_tgt != DEF));

    assign ARID_S   = ARID_M;
    assign ARADDR_S = ARADDR_M;
    assign ARLEN_S  = ARLEN_M;

    // AR steering: pick the decoded slave's ready and raise only its valid.
    always_comb begin
        w_sel_arready = 1'b0;
        ARVALID_S     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_tgt == target_e'(i)) begin
                w_sel_arready = ARREADY_S[i];
                ARVALID_S[i]  = !ARESET && ARVALID_M && w_adm;
            end
        end
        if (w_tgt == DEF)
            w_sel_arready = w_def_arready;
    end

    assign ARREADY_M     = !ARESET && w_adm && w_sel_arready;
    assign w_def_arvalid = !ARESET && ARVALID_M && w_adm && (w_tgt == DEF);
    assign w_ar_hs       = ARVALID_M && ARREADY_M;

    // R steering from the current target; nothing is routed while idle so stray
    // slave RVALIDs cannot reach the master.
    always_comb begin
        RVALID_M     = 1'b0;
        RID_M        = '0;
        RDATA_M      = '0;
        RRESP_M      = '0;
        RLAST_M      = 1'b0;
        RREADY_S     = '0;
        w_def_rready = 1'b0;
        if (!ARESET && w_busy) begin
            if (r_cur_tgt == DEF) begin
                RVALID_M     = w_def_rvalid;
                RID_M        = w_def_rid;
                RDATA_M      = w_def_rdata;
                RRESP_M      = w_def_rresp;
                RLAST_M      = w_def_rlast;
                w_def_rready = RREADY_M;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_cur_tgt == target_e'(i)) begin
                        RVALID_M    = RVALID_S[i];
                        RID_M       = RID_S[i];
                        RDATA_M     = RDATA_S[i];
                        RRESP_M     = RRESP_S[i];
                        RLAST_M     = RLAST_S[i];
                        RREADY_S[i] = RREADY_M;
                    end
                end
            end
        end
    end

    assign w_rlast_hs = RVALID_M && RREADY_M && RLAST_M;

    // Outstanding-burst count and current target; a simultaneous accept and
    // completion cancel out.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt     <= '0;
            r_cur_tgt <= SLV0;
        end else begin
            if (w_ar_hs)
                r_cur_tgt <= w_tgt;
            if (w_ar_hs && !w_rlast_hs)
                r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_ar_hs && w_rlast_hs)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    axi_default_rd_slave #(
        .ID_BITS   (ID_BITS),
        .DATA_BITS (DATA_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_def (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .i_arvalid (w_def_arvalid),
        .i_arid    (ARID_M),
        .i_arlen   (ARLEN_M),
        .o_arready (w_def_arready),
        .o_rvalid  (w_def_rvalid),
        .o_rid     (w_def_rid),
        .o_rdata   (w_def_rdata),
        .o_rresp   (w_def_rresp),
        .o_rlast   (w_def_rlast),
        .i_rready  (w_def_rready)
    );

endmodule
